// File: rtl/bow_pkg.sv
// Shared bow controller types and bow_state codes, also consumed by the bow colour block.
package bow_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DRAW     = 2'd1,
    ST_HOLD     = 2'd2,
    ST_COOLDOWN = 2'd3
  } bow_ctrl_state_t;

  localparam logic [3:0] BOW_REST        = 4'd0;
  localparam logic [3:0] BOW_FULL        = 4'd5;
  localparam logic [3:0] BOW_CROSS_LARGE = 4'd6;
  localparam logic [3:0] BOW_CROSS_SMALL = 4'd7;

  localparam logic [2:0] STAGE_NONE  = 3'd0;
  localparam logic [2:0] STAGE_FIRST = 3'd1;
  localparam logic [2:0] STAGE_FULL  = 3'd5;

  // Crosshair shown while the bow is at rest and idle.
  function automatic logic [3:0] idle_code(input logic aim);
    logic [3:0] code;
    if (aim) begin
      code = BOW_CROSS_LARGE;
    end else begin
      code = BOW_CROSS_SMALL;
    end
    return code;
  endfunction

endpackage

// File: rtl/bow_state_ctrl.sv
// Bow draw/hold/fire sequencer paced by the VGA frame tick; all outputs registered.
module bow_state_ctrl
  import bow_pkg::*;
#(
  parameter int FRAMES_PER_STAGE = 6,
  parameter int COOLDOWN_FRAMES  = 20,
  parameter int MIN_FIRE_STAGE   = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       draw_btn,
  input  logic       aim_btn,
  output logic [3:0] bow_state,
  output logic       fire,
  output logic [2:0] fire_power,
  output logic       busy
);

  localparam int CNT_MAX = (FRAMES_PER_STAGE > COOLDOWN_FRAMES) ? FRAMES_PER_STAGE : COOLDOWN_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(FRAMES_PER_STAGE - 1);
  localparam logic [CNT_W-1:0] COOL_LAST  = CNT_W'(COOLDOWN_FRAMES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [2:0]       FIRE_MIN   = 3'(MIN_FIRE_STAGE);

  bow_ctrl_state_t  state_r, state_s;
  logic [2:0]       stage_r, stage_s;
  logic [CNT_W-1:0] tick_cnt_r, tick_cnt_s;
  logic             draw_q_r;
  logic             fire_s;
  logic [2:0]       fire_power_s;
  logic [3:0]       bow_state_s;
  logic             busy_s;
  logic             press_s;

  assign press_s = draw_btn & ~draw_q_r;

  // State, counters and registered outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r    <= ST_IDLE;
      stage_r    <= STAGE_NONE;
      tick_cnt_r <= CNT_ZERO;
      draw_q_r   <= 1'b1;
      bow_state  <= BOW_CROSS_SMALL;
      fire       <= 1'b0;
      fire_power <= 3'd0;
      busy       <= 1'b0;
    end else begin
      state_r    <= state_s;
      stage_r    <= stage_s;
      tick_cnt_r <= tick_cnt_s;
      draw_q_r   <= draw_btn;
      bow_state  <= bow_state_s;
      fire       <= fire_s;
      fire_power <= fire_power_s;
      busy       <= busy_s;
    end
  end

  // Next-state logic; a release takes priority over a coincident frame tick.
  always_comb begin
    state_s      = state_r;
    stage_s      = stage_r;
    tick_cnt_s   = tick_cnt_r;
    fire_s       = 1'b0;
    fire_power_s = fire_power;
    case (state_r)
      ST_IDLE: begin
        if (press_s) begin
          state_s    = ST_DRAW;
          stage_s    = STAGE_FIRST;
          tick_cnt_s = CNT_ZERO;
        end else begin
          stage_s    = STAGE_NONE;
        end
      end
      ST_DRAW, ST_HOLD: begin
        if (!draw_btn) begin
          if (stage_r >= FIRE_MIN) begin
            state_s      = ST_COOLDOWN;
            fire_s       = 1'b1;
            fire_power_s = stage_r;
          end else begin
            state_s      = ST_IDLE;
          end
          stage_s    = STAGE_NONE;
          tick_cnt_s = CNT_ZERO;
        end else if ((state_r == ST_DRAW) && frame_tick) begin
          if (tick_cnt_r == STAGE_LAST) begin
            tick_cnt_s = CNT_ZERO;
            stage_s    = stage_r + 3'd1;
            if ((stage_r + 3'd1) == STAGE_FULL) begin
              state_s = ST_HOLD;
            end else begin
              state_s = ST_DRAW;
            end
          end else begin
            tick_cnt_s = tick_cnt_r + CNT_ONE;
          end
        end else begin
          tick_cnt_s = tick_cnt_r;
        end
      end
      ST_COOLDOWN: begin
        if (frame_tick) begin
          if (tick_cnt_r == COOL_LAST) begin
            state_s    = ST_IDLE;
            tick_cnt_s = CNT_ZERO;
          end else begin
            tick_cnt_s = tick_cnt_r + CNT_ONE;
          end
        end else begin
          tick_cnt_s = tick_cnt_r;
        end
      end
      default: begin
        state_s    = ST_IDLE;
        stage_s    = STAGE_NONE;
        tick_cnt_s = CNT_ZERO;
      end
    endcase
  end

  // Output decode from the upcoming state so the registered outputs line up with it.
  always_comb begin
    bow_state_s = BOW_REST;
    busy_s      = 1'b0;
    case (state_s)
      ST_IDLE: begin
        bow_state_s = idle_code(aim_btn);
        busy_s      = 1'b0;
      end
      ST_DRAW: begin
        bow_state_s = {1'b0, stage_s};
        busy_s      = 1'b1;
      end
      ST_HOLD: begin
        bow_state_s = BOW_FULL;
        busy_s      = 1'b1;
      end
      ST_COOLDOWN: begin
        bow_state_s = BOW_REST;
        busy_s      = 1'b1;
      end
      default: begin
        bow_state_s = BOW_CROSS_SMALL;
        busy_s      = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_bow_state_ctrl.sv
// Directed scoreboard bench for bow_state_ctrl with the default frame parameters.
module tb_bow_state_ctrl;

  logic       Clk;
  logic       Reset;
  logic       frame_tick;
  logic       draw_btn;
  logic       aim_btn;
  logic [3:0] bow_state;
  logic       fire;
  logic [2:0] fire_power;
  logic       busy;

  typedef struct {
    string      tag;
    logic [3:0] bs;
    logic       f;
    logic [2:0] pw;
    logic       b;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp;
  int   n_bad;

  bow_state_ctrl #(
    .FRAMES_PER_STAGE(6),
    .COOLDOWN_FRAMES (20),
    .MIN_FIRE_STAGE  (2)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_tick(frame_tick),
    .draw_btn  (draw_btn),
    .aim_btn   (aim_btn),
    .bow_state (bow_state),
    .fire      (fire),
    .fire_power(fire_power),
    .busy      (busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Monitor: each cycle the outputs present a new registered snapshot; compare against the queued expectation.
  always @(negedge Clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_cmp++;
      if (bow_state !== e.bs || fire !== e.f || fire_power !== e.pw || busy !== e.b) begin
        n_bad++;
        $display("FAIL %s: got bow_state=%0d fire=%0b power=%0d busy=%0b, want bow_state=%0d fire=%0b power=%0d busy=%0b",
                 e.tag, bow_state, fire, fire_power, busy, e.bs, e.f, e.pw, e.b);
      end
    end
  end

  // Drive one cycle of inputs and queue the outputs expected right after that edge.
  task automatic step(input string tag, input logic r, input logic d, input logic a, input logic t,
                      input logic [3:0] bs, input logic f, input logic [2:0] pw, input logic b);
    exp_t e;
    Reset = r; draw_btn = d; aim_btn = a; frame_tick = t;
    @(posedge Clk);
    #1;
    e.tag = tag; e.bs = bs; e.f = f; e.pw = pw; e.b = b;
    exp_q.push_back(e);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    Reset = 1'b1; draw_btn = 1'b0; aim_btn = 1'b0; frame_tick = 1'b0;

    // Reset state and aim crosshair in idle.
    step("reset",      1'b1, 1'b0, 1'b0, 1'b0, 4'd7, 1'b0, 3'd0, 1'b0);
    step("idle_aim",   1'b0, 1'b0, 1'b1, 1'b0, 4'd6, 1'b0, 3'd0, 1'b0);
    step("idle_noaim", 1'b0, 1'b0, 1'b0, 1'b0, 4'd7, 1'b0, 3'd0, 1'b0);

    // Full draw: stage = 1 + ticks/6, HOLD at tick 24.
    step("press", 1'b0, 1'b1, 1'b1, 1'b0, 4'd1, 1'b0, 3'd0, 1'b1);
    for (int i = 1; i <= 24; i++) begin
      step("draw_tick", 1'b0, 1'b1, 1'b0, 1'b1, 4'(1 + i / 6), 1'b0, 3'd0, 1'b1);
    end
    for (int i = 0; i < 3; i++) begin
      step("hold_tick", 1'b0, 1'b1, 1'b1, 1'b1, 4'd5, 1'b0, 3'd0, 1'b1);
    end

    // Release from HOLD, then 20 cooldown ticks with a stray press mid-way.
    step("fire_full", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 3'd5, 1'b1);
    for (int j = 1; j <= 19; j++) begin
      if (j == 10) begin
        step("cool_press", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 3'd5, 1'b1);
      end
      step("cool_tick", 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 3'd5, 1'b1);
    end
    step("cool_end", 1'b0, 1'b0, 1'b0, 1'b1, 4'd7, 1'b0, 3'd5, 1'b0);

    // Early release at stage 1 cancels without firing.
    step("press2", 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0, 3'd5, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step("s1_tick", 1'b0, 1'b1, 1'b0, 1'b1, 4'd1, 1'b0, 3'd5, 1'b1);
    end
    step("cancel", 1'b0, 1'b0, 1'b0, 1'b0, 4'd7, 1'b0, 3'd5, 1'b0);

    // Release coincident with the 6th tick of stage 2 fires at power 2.
    step("press3", 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0, 3'd5, 1'b1);
    for (int i = 1; i <= 11; i++) begin
      step("to_s2", 1'b0, 1'b1, 1'b0, 1'b1, 4'(1 + i / 6), 1'b0, 3'd5, 1'b1);
    end
    step("fire_tick_race", 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b1, 3'd2, 1'b1);

    // Button re-pressed and held through cooldown expiry: no new draw.
    for (int j = 1; j <= 19; j++) begin
      step("cool_held", 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 3'd2, 1'b1);
    end
    step("cool_end_held", 1'b0, 1'b1, 1'b0, 1'b1, 4'd7, 1'b0, 3'd2, 1'b0);
    step("held_aim",      1'b0, 1'b1, 1'b1, 1'b0, 4'd6, 1'b0, 3'd2, 1'b0);
    step("held_noaim",    1'b0, 1'b1, 1'b0, 1'b0, 4'd7, 1'b0, 3'd2, 1'b0);
    step("let_go",        1'b0, 1'b0, 1'b0, 1'b0, 4'd7, 1'b0, 3'd2, 1'b0);

    // Fresh press with a coincident tick: that tick is not counted.
    step("press_tick", 1'b0, 1'b1, 1'b0, 1'b1, 4'd1, 1'b0, 3'd2, 1'b1);
    for (int i = 1; i <= 5; i++) begin
      step("uncounted", 1'b0, 1'b1, 1'b0, 1'b1, 4'd1, 1'b0, 3'd2, 1'b1);
    end
    step("adv_s2", 1'b0, 1'b1, 1'b0, 1'b1, 4'd2, 1'b0, 3'd2, 1'b1);
    for (int i = 1; i <= 18; i++) begin
      step("to_hold", 1'b0, 1'b1, 1'b0, 1'b1, 4'(2 + i / 6), 1'b0, 3'd2, 1'b1);
    end

    // Reset in HOLD aborts with no fire; held button must be re-pressed.
    step("reset_hold",   1'b1, 1'b1, 1'b1, 1'b0, 4'd7, 1'b0, 3'd0, 1'b0);
    step("held_post_rst", 1'b0, 1'b1, 1'b0, 1'b0, 4'd7, 1'b0, 3'd0, 1'b0);
    step("release_idle", 1'b0, 1'b0, 1'b0, 1'b0, 4'd7, 1'b0, 3'd0, 1'b0);

    // Reach COOLDOWN at power 2, then reset mid-cooldown.
    step("press4", 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0, 3'd0, 1'b1);
    for (int i = 1; i <= 6; i++) begin
      step("to_s2b", 1'b0, 1'b1, 1'b0, 1'b1, 4'(1 + i / 6), 1'b0, 3'd0, 1'b1);
    end
    step("fire_s2", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 3'd2, 1'b1);
    for (int j = 1; j <= 3; j++) begin
      step("cool_b", 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 3'd2, 1'b1);
    end
    step("reset_cool", 1'b1, 1'b0, 1'b1, 1'b1, 4'd7, 1'b0, 3'd0, 1'b0);
    step("aim_on",     1'b0, 1'b0, 1'b1, 1'b0, 4'd6, 1'b0, 3'd0, 1'b0);
    step("aim_off",    1'b0, 1'b0, 1'b0, 1'b0, 4'd7, 1'b0, 3'd0, 1'b0);

    @(negedge Clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
